vga_osd_writer: RTL
===================

Name: vga_osd_writer

Overview:
- Write-side producer for the 1-bit OSD bitmap RAM that the VGA controller reads out.
- Accepts commands over a valid/ready interface from the host/USB control path: set pointer, write byte, fill frame.
- Serialises each command into one-bit RAM writes (oWR_DATA/oWR_ADDR/oWR_EN) on the RAM write clock.
- Emits linear bit addresses; any bit-order remapping inside the RAM wrapper is not this block's concern.

Parameters:
- FRAME_BITS, 208000, OSD bitmap size in bits (520x400); valid addresses 0..FRAME_BITS-1.
- ADDR_W, 19, write address width.

Ports:
- iCLK  in  1  write clock; same clock as the RAM write port.
- iRST_N  in  1  asynchronous active-low reset.
- iCMD_VALID  in  1  command present.
- oCMD_READY  out  1  block can accept a command; high iff state==IDLE.
- iCMD_OP  in  2  opcode: 00 NOP, 01 SET_PTR, 10 WRITE_BYTE, 11 FILL.
- iCMD_ARG  in  19  operand: SET_PTR address, WRITE_BYTE data in [7:0], FILL value in [0].
- oWR_DATA  out  1  bit to write.
- oWR_ADDR  out  19  bit address.
- oWR_EN  out  1  write strobe; one bit per cycle.
- oBUSY  out  1  state!=IDLE.
- oERR  out  1  one-cycle pulse on a rejected SET_PTR.

Behaviour:
- Reset (async, any time, including mid-FILL or mid-byte):
  - state=IDLE, ptr=0, shift reg=0, bit count=0.
  - oWR_EN=0, oWR_DATA=0, oWR_ADDR=0, oERR=0.
  - No further writes are issued after reset.
- Handshake: a command is accepted on a rising edge where iCMD_VALID & oCMD_READY. iCMD_OP and iCMD_ARG are sampled only on that edge.
- Outputs oWR_* and oERR are registered. oCMD_READY and oBUSY are decoded from state.
- States:
  - IDLE: accepts commands.
  - SHIFT: 8-bit serialisation.
  - FILL: whole-frame sweep.
- NOP: accepted in one cycle; no write; state stays IDLE.
- SET_PTR:
  - If ARG<FRAME_BITS: ptr<=ARG; no write.
  - Otherwise ptr is unchanged and oERR is high for the following cycle.
  - State stays IDLE.
- WRITE_BYTE, MSB-first:
  - On the accept edge: oWR_EN=1, oWR_ADDR=ptr, oWR_DATA=ARG[7]; ptr advances; state=SHIFT, count=1.
  - Each following edge emits the next bit (ARG[6]..ARG[0]) at the advanced ptr.
  - The edge emitting ARG[0] returns state to IDLE.
  - oWR_EN is high for exactly 8 consecutive cycles starting the cycle after accept.
  - oCMD_READY is low for the first 7 of those cycles and high in the cycle showing bit0.
  - Back-to-back bytes therefore produce a gap-free write stream: 1 byte per 8 cycles.
- Pointer advance: ptr<=(ptr==FRAME_BITS-1)?0:ptr+1. A byte straddling the end wraps per bit (e.g. ptr=FRAME_BITS-3 writes FRAME_BITS-3..-1, then 0..4).
- FILL:
  - On the accept edge: oWR_EN=1, oWR_ADDR=0, oWR_DATA=ARG[0]; state=FILL.
  - Address increments each cycle up to FRAME_BITS-1. The edge emitting address FRAME_BITS-1 returns to IDLE and sets ptr=0.
  - Exactly FRAME_BITS writes are issued; oCMD_READY is low for FRAME_BITS-1 cycles.
- In IDLE with no accept: oWR_EN=0. oWR_ADDR and oWR_DATA hold their last values.
- iCMD_VALID while not ready is ignored. The command must be held by the source until accepted; no buffering.
- Arithmetic: ptr is ADDR_W bits and is never allowed to reach FRAME_BITS. The bit counter is 3 bits. The fill counter reuses ptr.

Decomposition:
- Shared package vga_osd_pkg holds:
  - opcode constants OP_NOP/OP_SET_PTR/OP_WRITE_BYTE/OP_FILL;
  - the FRAME_BITS and ADDR_W defaults;
  - the state encoding IDLE/SHIFT/FILL.
- One sub-module: vga_osd_bit_ptr, a wrapping address counter with synchronous load, increment, clear and async reset. The top instantiates it once; the FSM and serialiser stay in the top.

Test Plan:
- Reset then SET_PTR 100, WRITE_BYTE 0xA5 -> oWR_EN high 8 cycles, addresses 100..107, data 1,0,1,0,0,1,0,1; ready returns in the cycle showing addr 107.
- Two WRITE_BYTE 0xFF, 0x00 held valid continuously from ptr 0 -> 16 consecutive write cycles, addresses 0..15, no gap, data 8 ones then 8 zeros.
- SET_PTR FRAME_BITS-3 then WRITE_BYTE 0xF0 -> addresses 207997, 207998, 207999, 0, 1, 2, 3, 4; data 1,1,1,1,0,0,0,0; final ptr 5.
- SET_PTR 208000 -> oERR pulses one cycle, no write, next WRITE_BYTE starts at the previous ptr.
- FILL value 1 -> exactly 208000 writes, addresses 0..207999, all data 1, then ptr 0 and ready high.
- Assert iRST_N low at fill address 5000 -> oWR_EN drops immediately (async), ready high after release, a subsequent WRITE_BYTE writes addresses 0..7.

Source files
------------

// File: rtl/vga_osd_pkg.sv
// vga_osd_pkg: opcodes, sizing defaults and FSM encoding shared by the OSD bitmap writer.
package vga_osd_pkg;
    localparam int DEF_FRAME_BITS = 208000;
    localparam int DEF_ADDR_W = 19;
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET_PTR = 2'b01;
    localparam logic [1:0] OP_WRITE_BYTE = 2'b10;
    localparam logic [1:0] OP_FILL = 2'b11;
    typedef enum logic [1:0] {IDLE, SHIFT, FILL} stateT;
endpackage

// File: rtl/vga_osd_bit_ptr.sv
// vga_osd_bit_ptr: bit address counter that wraps from FRAME_BITS-1 back to 0.
module vga_osd_bit_ptr
    import vga_osd_pkg::*;
#(
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iClr,
    input  logic              iLoad,
    input  logic [ADDR_W-1:0] iLoadVal,
    input  logic              iInc,
    output logic [ADDR_W-1:0] oPtr
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_BITS - 1);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) oPtr <= '0;
        else if (iClr) oPtr <= '0;
        else if (iLoad) oPtr <= iLoadVal;
        else if (iInc) oPtr <= (oPtr == LAST) ? '0 : oPtr + 1'b1;
    end
endmodule

// File: rtl/vga_osd_writer.sv
// vga_osd_writer: turns host commands (set pointer, write byte, fill frame)
// into a one-bit-per-cycle write stream for the OSD bitmap RAM.
module vga_osd_writer
    import vga_osd_pkg::*;
#(
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iCMD_VALID,
    output logic              oCMD_READY,
    input  logic [1:0]        iCMD_OP,
    input  logic [ADDR_W-1:0] iCMD_ARG,
    output logic              oWR_DATA,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic              oWR_EN,
    output logic              oBUSY,
    output logic              oERR
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_BITS - 1);

    stateT state;
    logic [7:0] shiftReg;
    logic [2:0] bitCnt;
    logic [ADDR_W-1:0] ptr, loadVal;
    logic accept, ptrLoad, ptrInc, ptrClr;

    assign oCMD_READY = state == IDLE;
    assign oBUSY = state != IDLE;
    assign accept = iCMD_VALID && oCMD_READY;

    // FILL reuses ptr as its sweep counter: address 0 goes out on accept, so ptr starts at 1
    always_comb begin
        ptrClr = state == FILL && ptr == LAST;
        ptrLoad = accept && (iCMD_OP == OP_FILL || (iCMD_OP == OP_SET_PTR && iCMD_ARG <= LAST));
        loadVal = (iCMD_OP == OP_FILL) ? ADDR_W'(1) : iCMD_ARG;
        ptrInc = state != IDLE || (accept && iCMD_OP == OP_WRITE_BYTE);
    end

    vga_osd_bit_ptr #(.FRAME_BITS(FRAME_BITS), .ADDR_W(ADDR_W)) bitPtr (
        .iCLK(iCLK),
        .iRST_N(iRST_N),
        .iClr(ptrClr),
        .iLoad(ptrLoad),
        .iLoadVal(loadVal),
        .iInc(ptrInc),
        .oPtr(ptr)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= IDLE;
            shiftReg <= '0;
            bitCnt <= '0;
            oWR_EN <= 1'b0;
            oWR_DATA <= 1'b0;
            oWR_ADDR <= '0;
            oERR <= 1'b0;
        end else begin
            oERR <= 1'b0;
            oWR_EN <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    case (iCMD_OP)
                        OP_SET_PTR: oERR <= iCMD_ARG > LAST;
                        OP_WRITE_BYTE: begin
                            oWR_EN <= 1'b1;
                            oWR_ADDR <= ptr;
                            oWR_DATA <= iCMD_ARG[7];
                            shiftReg <= {iCMD_ARG[6:0], 1'b0};
                            bitCnt <= 3'd1;
                            state <= SHIFT;
                        end
                        OP_FILL: begin
                            oWR_EN <= 1'b1;
                            oWR_ADDR <= '0;
                            oWR_DATA <= iCMD_ARG[0];
                            state <= FILL;
                        end
                        default: ;
                    endcase
                end
                SHIFT: begin
                    oWR_EN <= 1'b1;
                    oWR_ADDR <= ptr;
                    oWR_DATA <= shiftReg[7];
                    shiftReg <= shiftReg << 1;
                    bitCnt <= bitCnt + 3'd1;
                    if (bitCnt == 3'd7) state <= IDLE;
                end
                FILL: begin
                    oWR_EN <= 1'b1;
                    oWR_ADDR <= ptr;
                    if (ptr == LAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
